serial_frame_rcv: RTL and testbench
===================================

// Module: serial_frame_rcv
// PURPOSE
// Serial framing receiver sitting directly downstream of the high-reset synchronizer (sync_high).
// Consumes the synchronized serial line (idle high) and detects the start-bit falling edge.
// Samples each bit at mid-period with a bit-timing counter and shifts the data in LSB-first.
// Checks the stop bit, then presents a parallel byte with ready, overrun and framing-error flags.
// PARAMETERS
// CLKS_PER_BIT  10  clocks per serial bit; legal range >= 4; HALF = CLKS_PER_BIT/2 (integer divide)
// DATA_BITS      8  data bits per frame; legal range 1..16
// PORTS
// clk            in   1          system clock, all state on rising edge
// n_rst          in   1          asynchronous, active-low reset
// serial_in      in   1          synchronized serial line (sync_high output); idle = 1
// data_read      in   1          consumer has taken rx_data; one-cycle pulse
// rx_data        out  DATA_BITS  last good frame payload, LSB = first bit received
// data_ready     out  1          rx_data holds an unread good frame
// overrun_error  out  1          good frame was loaded while the previous frame was still unread
// framing_error  out  1          most recent frame had stop bit = 0
// busy           out  1          FSM not in IDLE
// BEHAVIOUR
// - Reset (async, n_rst=0): rx_data = all 1s; data_ready, overrun_error, framing_error, busy = 0.
//   Also on reset: FSM = IDLE; counters = 0; shift register = all 1s; edge register prev = 1.
// - Edge detect: prev <= serial_in every cycle; start_edge = prev & ~serial_in (combinational).
// - FSM states: IDLE, START, DATA, STOP, LOAD; cnt = bit-timer counter; bit_idx = data bit counter.
// - IDLE: on start_edge -> START, cnt = 0. Otherwise stay in IDLE.
// - START: cnt increments each cycle; at cnt == HALF-1, sample serial_in.
//   If sampled 1: false start -> IDLE, no flag changes. If sampled 0: -> DATA, cnt = 0, bit_idx = 0.
// - DATA: at cnt == CLKS_PER_BIT-1, sample serial_in into the shift register (shift right, new bit
//   enters at MSB), bit_idx++ and cnt = 0. After the DATA_BITS-th sample -> STOP.
// - STOP: at cnt == CLKS_PER_BIT-1, capture stop bit -> LOAD.
// - LOAD (1 cycle, then -> IDLE):
//   Stop = 1: rx_data <= shift register; data_ready <= 1; overrun_error <= data_ready & ~data_read;
//   framing_error <= 0.
//   Stop = 0: framing_error <= 1; rx_data, data_ready and overrun_error unchanged.
// - Timing: T = first cycle serial_in = 0 after being 1. Data bit i is sampled at T+HALF+(i+1)*CLKS_PER_BIT.
//   The stop bit is sampled at T+HALF+(DATA_BITS+1)*CLKS_PER_BIT.
//   Outputs are visible from T+HALF+(DATA_BITS+1)*CLKS_PER_BIT+2 (defaults: T+97).
// - data_read (any cycle other than LOAD): clears data_ready and overrun_error next cycle.
//   framing_error is unaffected by data_read.
// - data_read in the same cycle as a good LOAD: LOAD wins; data_ready stays 1, overrun_error <= 0.
// - A line held low after a bad stop bit does not retrigger; a new frame needs a 1->0 transition.
// - A start_edge seen in any state other than IDLE is ignored. There is no resync mid-frame.
// - busy = (state != IDLE), registered-state decode.
// - cnt width = clog2(CLKS_PER_BIT); bit_idx width = clog2(DATA_BITS+1); no wrap beyond terminal values.
// - Reset asserted mid-frame: immediate return to the reset values above; the partial frame is discarded.
// TESTING
// 1) Defaults; idle 1s, then frame 0|0xA5 LSB-first|1 at 10 clk/bit -> rx_data=0xA5, data_ready=1 at T+97.
//    busy is high from T+1 through the LOAD cycle.
// 2) serial_in low for 3 cycles then high -> returns to IDLE at T+6; no flag or rx_data change.
// 3) Frame 0x3C with stop bit = 0 -> framing_error=1; data_ready=0; rx_data keeps 0xFF (reset value).
//    A following good frame 0x01 -> framing_error=0, rx_data=0x01.
// 4) Good frames 0x11 then 0x22, no data_read -> rx_data=0x22, data_ready=1, overrun_error=1.
//    Then a data_read pulse -> data_ready=0 and overrun_error=0 next cycle.
// 5) data_read pulsed exactly in the LOAD cycle of a second frame -> data_ready=1, overrun_error=0.
// 6) n_rst low during data bit 4 of a frame -> all outputs at reset values immediately; busy=0.
//    Then a full frame 0x5A -> received correctly.

Source files
------------

// File: rtl/serial_frame_rcv.sv
// Serial framing receiver: start-edge detect, mid-bit sampling, LSB-first shift-in,
// stop-bit check and a parallel byte with ready / overrun / framing-error flags.
module serial_frame_rcv #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_LOAD
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, shift_in;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 stop_q, stop_d;
  logic                 ready_q, ready_d;
  logic                 overrun_q, overrun_d;
  logic                 ferr_q, ferr_d;
  logic                 prev_q;
  logic                 start_edge;

  assign start_edge = prev_q & ~serial_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '1;
      rx_data_q <= '1;
      stop_q    <= 1'b0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      stop_q    <= stop_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      prev_q    <= serial_in;
    end
  end

  // Shift right with the new bit at the MSB; written this way so DATA_BITS == 1 is legal.
  always_comb begin
    shift_in                = shift_q >> 1;
    shift_in[DATA_BITS-1]   = serial_in;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    stop_d    = stop_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;

    if (data_read) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = serial_in ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d   = shift_in;
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          stop_d  = serial_in;
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_LOAD: begin
        state_d = S_IDLE;
        // A bad stop bit leaves the previous payload and its flags untouched.
        if (stop_q) begin
          rx_data_d = shift_q;
          ready_d   = 1'b1;
          overrun_d = ready_q & ~data_read;
          ferr_d    = 1'b0;
        end else begin
          ready_d   = ready_q;
          overrun_d = overrun_q;
          ferr_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rcv.sv
// Directed bench for serial_frame_rcv at default parameters (10 clk/bit, 8 data bits).
module tb_serial_frame_rcv;

  logic       clk;
  logic       n_rst;
  logic       serial_in;
  logic       data_read;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       busy;

  int errors = 0;
  int checks = 0;

  serial_frame_rcv #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Line value in cycle k of a frame whose start bit is first seen at edge k=0.
  function automatic logic frame_bit(input logic [7:0] data, input logic stop, input int k);
    if (k < 10)       return 1'b0;
    else if (k < 90)  return data[(k - 10) / 10];
    else if (k < 100) return stop;
    else              return 1'b1;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      serial_in = 1'b1;
      data_read = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input logic [7:0] data, input logic stop, input int tail_len,
                           input logic tail_val, input int read_k, input int abort_k);
    for (int k = 0; k < 100 + tail_len; k++) begin
      if (k == abort_k) return;
      serial_in = (k < 100) ? frame_bit(data, stop, k) : tail_val;
      data_read = (k == read_k);
      @(posedge clk);
      #1;
    end
    data_read = 1'b0;
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    @(posedge clk);
    #1;
    data_read = 1'b0;
  endtask

  initial begin
    serial_in = 1'b1;
    data_read = 1'b0;
    n_rst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_data", rx_data, 32'hFF);
    chk("rst_ready", data_ready, 0);
    chk("rst_overrun", overrun_error, 0);
    chk("rst_framing", framing_error, 0);
    chk("rst_busy", busy, 0);
    n_rst = 1'b1;
    idle(5);

    // 1) good frame 0xA5, cycle-accurate busy / ready timing
    for (int k = 0; k < 110; k++) begin
      serial_in = frame_bit(8'hA5, 1'b1, k);
      @(posedge clk);
      #1;
      if (k == 0) chk("t1_busy_T1", busy, 1);
      if (k == 95) begin
        chk("t1_busy_load", busy, 1);
        chk("t1_ready_early", data_ready, 0);
      end
      if (k == 96) begin
        chk("t1_busy_done", busy, 0);
        chk("t1_ready", data_ready, 1);
        chk("t1_rx_data", rx_data, 32'hA5);
        chk("t1_overrun", overrun_error, 0);
        chk("t1_framing", framing_error, 0);
      end
    end

    // 2) false start: low for 3 cycles
    for (int k = 0; k < 12; k++) begin
      serial_in = (k < 3) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (k == 4) chk("t2_busy_start", busy, 1);
      if (k == 5) chk("t2_busy_idle", busy, 0);
    end
    chk("t2_rx_data", rx_data, 32'hA5);
    chk("t2_ready", data_ready, 1);
    chk("t2_framing", framing_error, 0);

    // 3) bad stop bit from reset, line held low afterwards, then good 0x01
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    idle(5);
    run_frame(8'h3C, 1'b0, 20, 1'b0, -1, -1);
    chk("t3_framing", framing_error, 1);
    chk("t3_ready", data_ready, 0);
    chk("t3_rx_keep", rx_data, 32'hFF);
    chk("t3_no_retrig", busy, 0);
    idle(5);
    run_frame(8'h01, 1'b1, 5, 1'b1, -1, -1);
    chk("t3_framing_clr", framing_error, 0);
    chk("t3_rx_data", rx_data, 32'h01);
    chk("t3_ready", data_ready, 1);

    // 4) overrun from two unread frames, cleared by data_read
    pulse_read();
    chk("t4_read_clr", data_ready, 0);
    run_frame(8'h11, 1'b1, 5, 1'b1, -1, -1);
    chk("t4_rx_11", rx_data, 32'h11);
    chk("t4_ovr_first", overrun_error, 0);
    run_frame(8'h22, 1'b1, 5, 1'b1, -1, -1);
    chk("t4_rx_22", rx_data, 32'h22);
    chk("t4_ready", data_ready, 1);
    chk("t4_overrun", overrun_error, 1);
    pulse_read();
    chk("t4_ready_clr", data_ready, 0);
    chk("t4_ovr_clr", overrun_error, 0);

    // 5) data_read coincident with LOAD of a second frame
    run_frame(8'h33, 1'b1, 5, 1'b1, -1, -1);
    chk("t5_ready_33", data_ready, 1);
    run_frame(8'h44, 1'b1, 5, 1'b1, 96, -1);
    chk("t5_rx_44", rx_data, 32'h44);
    chk("t5_ready", data_ready, 1);
    chk("t5_overrun", overrun_error, 0);

    // bad frame keeps payload and ready, sets framing_error
    run_frame(8'h00, 1'b0, 10, 1'b1, -1, -1);
    chk("t5b_framing", framing_error, 1);
    chk("t5b_ready", data_ready, 1);
    chk("t5b_rx_keep", rx_data, 32'h44);

    // 6) asynchronous reset during data bit 4, then good 0x5A
    run_frame(8'h5A, 1'b1, 0, 1'b1, -1, 55);
    chk("t6_busy_mid", busy, 1);
    serial_in = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("t6_rst_rx", rx_data, 32'hFF);
    chk("t6_rst_ready", data_ready, 0);
    chk("t6_rst_ovr", overrun_error, 0);
    chk("t6_rst_ferr", framing_error, 0);
    chk("t6_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(5);
    run_frame(8'h5A, 1'b1, 5, 1'b1, -1, -1);
    chk("t6_rx_5A", rx_data, 32'h5A);
    chk("t6_ready", data_ready, 1);
    chk("t6_framing", framing_error, 0);
    chk("t6_overrun", overrun_error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
